multiword_add_seq: RTL and testbench
====================================

# multiword_add_seq

Multi-cycle sequencer that adds two wide operands by time-sharing one 16-bit ripple-carry add slice, one 16-bit word per clock, least-significant word first. The carry out of each slice is registered and fed back as carry-in to the next slice. It sits between a requester issuing START/operand pulses and the arithmetic datapath, so wide additions never need a full-width ripple chain.

## Interface
- WORDS, 4, number of 16-bit slices per operand; legal range 2..8; operand width N = 16*WORDS.

- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  reset; synchronous, active-high.
- START  input  1  request; sampled only when BUSY=0.
- A  input  N  operand A; captured on the accepting edge.
- B  input  N  operand B; captured on the accepting edge.
- BUSY  output  1  high while slices are being computed.
- DONE  output  1  one-cycle pulse; S/COUT hold the new result.
- S  output  N  sum, updated only on entry to DONE.
- COUT  output  1  carry out of the top slice, updated with S.

## Operation
- The block instantiates one 16-bit add slice: a full_adder chain with carry-in, so bit 0 also takes the registered carry.
- State machine with three states:
  - IDLE → RUN on START: capture A and B into working shift registers; slice index = 0; carry register = initial carry (0).
  - RUN: slice i = A_w[15:0] + B_w[15:0] + carry.
    - At each edge, the slice sum shifts into the top of the working result register, the carry register takes the slice carry-out, both operand registers shift right 16 bits, and the index increments.
    - When index = WORDS-1: go to DONE; copy the full working result to S and the final carry to COUT.
  - DONE (one cycle): START=1 → RUN, accepted exactly as from IDLE; otherwise → IDLE.
- START while BUSY=1 is ignored; it is not queued and operands are not captured.
- S and COUT hold the last result through IDLE and RUN; they are never intermediate values.
- Arithmetic is modulo 2^N. COUT is the true carry out of bit N-1. No signed overflow flag.
- Index counter width is clog2(WORDS); it never wraps inside a run.
- RST at any edge, including mid-RUN or during DONE, has priority over START:
  - state = IDLE;
  - S, COUT, BUSY, DONE, carry and index = 0;
  - working registers = 0.

## Timing
- Reset values: S=0, COUT=0, BUSY=0, DONE=0.
- START accepted at edge n:
  - BUSY=1 for exactly WORDS cycles, following edges n .. n+WORDS-1.
  - After edge n+WORDS: DONE=1 for one cycle, BUSY=0, and S/COUT hold the new result.
- Latency from the accepting edge to the DONE cycle is WORDS edges.
- Back-to-back throughput is one result every WORDS+1 cycles, with START held or re-asserted during DONE.
- BUSY and DONE are registered and never high in the same cycle.

## Configuration
- MWADD_SUB_EN defined:
  - Adds input SUB (1 bit), captured with A/B on the accepting edge.
  - SUB=1: B slices are bit-inverted before the slice and the initial carry is 1, so S = A - B mod 2^N and COUT=1 means no borrow.
  - SUB=0: identical to the macro-absent behaviour.
- MWADD_SUB_EN undefined: no SUB port; initial carry is always 0; addition only.

## Test plan
All scenarios use WORDS=4.
- Reset: hold RST two cycles → S=0, COUT=0, BUSY=0, DONE=0; then START with A=B=0 → S=0, COUT=0, DONE exactly 4 cycles after the accepting edge.
- Carry between slices: A=0x0000_0000_0000_FFFF, B=0x1 → S=0x0000_0000_0001_0000, COUT=0; BUSY high exactly 4 cycles.
- Full carry ripple: A=0xFFFF_FFFF_FFFF_FFFF, B=0x1 → S=0, COUT=1. During RUN, S still shows the previous result.
- START handling:
  - START with A=5, B=7 while BUSY=1 is ignored; the result stays that of the accepted operands.
  - START with A=1, B=2 asserted during the DONE cycle → BUSY=1 next cycle; S=0x3 after the following 4-cycle run.
- Reset mid-operation: RST in the second RUN cycle → next cycle S=0, COUT=0, BUSY=0, DONE=0; a fresh START with A=2, B=3 then yields S=0x5.
- With MWADD_SUB_EN:
  - SUB=1, A=0, B=1 → S=0xFFFF_FFFF_FFFF_FFFF, COUT=0.
  - SUB=1, A=B=0x1234_5678_9ABC_DEF0 → S=0, COUT=1.

Source files
------------

// File: rtl/multiword_add_seq_if.sv
// Request/result bundle for the word-serial wide adder.
// The optional SUB request bit exists only when MWADD_SUB_EN is defined.
interface multiword_add_seq_if #(
  parameter int WORDS = 4
);
  localparam int N = 16 * WORDS;

  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
`ifdef MWADD_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [N-1:0] s;
  logic         cout;

  // Requester side: issues operands, observes status and result
  modport master (
    output start, a, b,
`ifdef MWADD_SUB_EN
    output sub,
`endif
    input  busy, done, s, cout
  );

  // Adder side: accepts operands, returns status and result
  modport slave (
    input  start, a, b,
`ifdef MWADD_SUB_EN
    input  sub,
`endif
    output busy, done, s, cout
  );
endinterface

// File: rtl/multiword_add_seq.sv
// Word-serial wide adder: one 16-bit ripple slice is reused WORDS times,
// least-significant word first, with the slice carry registered between words.
// Optional feature macro: MWADD_SUB_EN adds a SUB request bit (A - B mode).
module multiword_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  multiword_add_seq_if.slave  bus
);
  localparam int N  = 16 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  r_q, r_d;
  logic [N-1:0]  s_q, s_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [15:0]   slice_sum;
  logic [16:0]   chain;
  logic [N-1:0]  b_in;
  logic          init_carry;

  // Subtraction is folded in at capture time: invert B once and seed carry with 1
`ifdef MWADD_SUB_EN
  assign b_in       = bus.sub ? ~bus.b : bus.b;
  assign init_carry = bus.sub;
`else
  assign b_in       = bus.b;
  assign init_carry = 1'b0;
`endif

  // The single shared 16-bit slice: full-adder ripple chain fed by the carry register
  assign chain[0] = carry_q;
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_fa
      assign slice_sum[gi] = a_q[gi] ^ b_q[gi] ^ chain[gi];
      assign chain[gi+1]   = (a_q[gi] & b_q[gi]) | (chain[gi] & (a_q[gi] ^ b_q[gi]));
    end
  endgenerate

  // Next-state logic: accept in IDLE/DONE, shift one word per cycle in RUN
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_RUN;
          a_d     = bus.a;
          b_d     = b_in;
          r_d     = '0;
          carry_d = init_carry;
          idx_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // Newest slice enters at the top so after WORDS shifts word 0 sits at the bottom
        r_d     = {slice_sum, r_q[N-1:16]};
        a_d     = a_q >> 16;
        b_d     = b_q >> 16;
        carry_d = chain[16];
        idx_d   = idx_q + IW'(1);
        if (idx_q == IW'(WORDS - 1)) begin
          state_d = S_DONE;
          s_d     = {slice_sum, r_q[N-1:16]};
          cout_d  = chain[16];
          idx_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset taking priority over any request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  // Status decodes straight from the state register, so BUSY and DONE are exclusive
  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);
  assign bus.s    = s_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq with WORDS=4 (64-bit operands).
module tb_multiword_add_seq;
  localparam int WORDS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  multiword_add_seq_if #(.WORDS(WORDS)) bus ();

  multiword_add_seq #(.WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and follow it to its DONE cycle; returns with DONE high.
  // poke=1 raises a stray START (A=5,B=7) mid-run that must be ignored.
  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic sub, input logic [63:0] exp_s, input logic exp_c,
                       input logic [63:0] prev_s, input logic prev_c, input logic poke);
    int lat;
    int nbusy;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
`ifdef MWADD_SUB_EN
    bus.sub   = sub;
`endif
    tick();
    bus.start = 1'b0;
    lat   = 0;
    nbusy = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) nbusy++;
      chk({tag, "_hold_s"}, bus.s, prev_s);
      chk({tag, "_hold_c"}, {63'd0, bus.cout}, {63'd0, prev_c});
      if (poke && lat == 1) begin
        bus.start = 1'b1;
        bus.a     = 64'd5;
        bus.b     = 64'd7;
      end
      if (poke && lat == 2) bus.start = 1'b0;
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'd4);
    chk({tag, "_nbusy"}, 64'(nbusy), 64'd4);
    chk({tag, "_busy_in_done"}, {63'd0, bus.busy}, 64'd0);
    chk({tag, "_s"}, bus.s, exp_s);
    chk({tag, "_cout"}, {63'd0, bus.cout}, {63'd0, exp_c});
    $display("op %s a=%h b=%h sub=%0d -> s=%h cout=%0d lat=%0d",
             tag, a, b, sub, bus.s, bus.cout, lat);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef MWADD_SUB_EN
    bus.sub   = 1'b0;
`endif
    rst = 1'b1;
    tick();
    tick();
    chk("rst_s", bus.s, 64'd0);
    chk("rst_cout", {63'd0, bus.cout}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    rst = 1'b0;
    tick();

    do_op("zero", 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
    tick();
    chk("done_pulse", {63'd0, bus.done}, 64'd0);

    do_op("slice_carry", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0,
          64'h0000_0000_0001_0000, 1'b0, 64'd0, 1'b0, 1'b0);
    tick();

    do_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
          64'd0, 1'b1, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    tick();

    do_op("mixed", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
          64'h2222_2222_2222_2211, 1'b0, 64'd0, 1'b1, 1'b0);
    tick();

    do_op("top_carry", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0,
          64'd1, 1'b1, 64'h2222_2222_2222_2211, 1'b0, 1'b0);
    tick();

    // Stray START mid-run, then a new request accepted straight from DONE
    do_op("ignore", 64'h10, 64'h20, 1'b0, 64'h30, 1'b0, 64'd1, 1'b1, 1'b1);
    do_op("b2b", 64'd1, 64'd2, 1'b0, 64'h3, 1'b0, 64'h30, 1'b0, 1'b0);
    tick();
    chk("idle_after_b2b", {62'd0, bus.busy, bus.done}, 64'd0);

    // Reset landing in the second RUN cycle
    bus.start = 1'b1;
    bus.a     = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.b     = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    bus.start = 1'b0;
    tick();
    chk("mid_busy", {63'd0, bus.busy}, 64'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_s", bus.s, 64'd0);
    chk("mid_rst_cout", {63'd0, bus.cout}, 64'd0);
    chk("mid_rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("mid_rst_done", {63'd0, bus.done}, 64'd0);
    rst = 1'b0;
    tick();
    do_op("after_rst", 64'd2, 64'd3, 1'b0, 64'h5, 1'b0, 64'd0, 1'b0, 1'b0);
    tick();

`ifdef MWADD_SUB_EN
    do_op("sub_borrow", 64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
          64'h5, 1'b0, 1'b0);
    tick();
    do_op("sub_equal", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1,
          64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    tick();
    do_op("sub_off", 64'd9, 64'd4, 1'b0, 64'd13, 1'b0, 64'd0, 1'b1, 1'b0);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
